qk_tile_sequencer: RTL and testbench
====================================

Name: qk_tile_sequencer

Overview:
- Sequences one row of mac_col instances, chained column-to-column through the 2-bit inst bus, for Q·K tile processing.
- Issues reads from a double-buffered activation SRAM (two banks, filled externally) and drives the array's inst stream aligned to the returned data.
- Throttles execution against output-FIFO almost-full and releases each bank back to the filler when its tile completes.
- Sits between the host/top-level control and the first column of the MAC array.

Parameters:
- COL, 8, number of MAC columns in the chain.
- LOAD_LEN, 10, load-phase cycles (COL+2); the column with the highest col_id latches its key last.
- N_Q, 8, query vectors executed per tile.
- DRAIN_LEN, 14, idle cycles after the last execute so results reach the output FIFO (pipeline depth 6 + COL).
- AW, 8, SRAM address width.
- BANK_STRIDE, 128, word offset between bank 0 and bank 1.
- Q_OFF, 16, query-region offset within a bank; keys occupy bank offsets 0..LOAD_LEN-1.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle pulse that begins a run.
- cfg_tiles, input, 8, tiles in the run; sampled on an accepted start; 0 means 256.
- bank_valid, input, 2, per-bank level: bank is filled and ready.
- ofifo_afull, input, 1, output FIFO cannot absorb DRAIN_LEN more writes.
- mem_rd_en, output, 1, SRAM read strobe.
- mem_rd_addr, output, AW, SRAM read address.
- o_inst, output, 2, to column 0: [1] execute, [0] load.
- bank_release, output, 2, one-cycle one-hot pulse freeing a bank.
- busy, output, 1, high from accepted start until done.
- done, output, 1, one-cycle pulse after the final tile drains.
- tile_cnt, output, 8, tiles completed in the current run.

Behaviour:
- Reset: synchronous, active-high, clock clk. All outputs 0; FSM=IDLE; bank_sel=0; counters cleared. Reset mid-run aborts immediately with no bank_release or done.
- FSM states:
  - IDLE: start accepted only here (ignored while busy). On accept: latch cfg_tiles, busy=1, tile_cnt=0, go to WAIT_BANK.
  - WAIT_BANK: no reads. When bank_valid[bank_sel]=1, go to LOAD with phase counter 0.
  - LOAD: for LOAD_LEN cycles, mem_rd_en=1 and mem_rd_addr=bank_sel*BANK_STRIDE+k, k=0..LOAD_LEN-1. Never stalls. Then go to EXEC.
  - EXEC: issue N_Q reads at bank_sel*BANK_STRIDE+Q_OFF+q.
    - A read issues only in cycles where ofifo_afull=0.
    - When afull=1: mem_rd_en=0, address holds, q holds.
    - After the N_Q-th issue, go to DRAIN.
  - DRAIN: DRAIN_LEN cycles with no reads; ofifo_afull is ignored. At exit, in the same cycle:
    - pulse bank_release[bank_sel];
    - toggle bank_sel;
    - tile_cnt+1.
    - If tiles remain, go to WAIT_BANK; otherwise pulse done, drop busy, go to IDLE.
- o_inst timing: registered, following mem_rd_en by exactly 1 cycle (SRAM read latency 1).
  - o_inst = 2'b01 one cycle after each LOAD read.
  - o_inst = 2'b10 one cycle after each EXEC read.
  - o_inst = 2'b00 otherwise, including stall bubbles.
  - o_inst is never 2'b11.
- Width rules: address computed modulo 2^AW; tile_cnt wraps modulo 256.
- Simultaneous events:
  - bank_valid may drop after LOAD begins without effect; the bank is owned until bank_release.
  - When DRAIN ends on the last tile, done and bank_release pulse in the same cycle.
  - start coincident with done is ignored.
  - start during reset is ignored.

Test Plan:
- Single tile: cfg_tiles=1, bank_valid=2'b01, afull=0, start → reads 0..9 then 16..23 contiguous; o_inst shows 10×01 then 8×10, each 1 cycle after its read; bank_release=01 and done at cycle 1+10+8+14 after WAIT_BANK exit; busy falls with done.
- Double buffering: cfg_tiles=3, bank_valid=11 → tile addresses based at 0, 128, 0; bank_release sequence 01,10,01; tile_cnt 1,2,3; one done.
- Bank starvation: cfg_tiles=2, bank_valid=01 → after tile 0, holds WAIT_BANK with mem_rd_en=0; raise bit1 after 20 cycles → LOAD at address 128 the next cycle.
- Backpressure: afull high for EXEC cycles 3–5 → queries 16..18 issue, 3 bubbles (o_inst=00), then 19..23; exactly 8 execute beats; afull asserted during LOAD or DRAIN is ignored.
- Abort/ignore: reset mid-EXEC → next cycle all outputs 0, bank_sel=0, no release; start while busy → no effect on tile count.
- cfg_tiles=0 → 256 tiles, tile_cnt wraps to 0, done after the 256th release.

Source files
------------

// File: rtl/qk_tile_sequencer.sv
// Q.K tile sequencer: walks a double-buffered activation SRAM, one tile per bank,
// and drives the load/execute inst stream into column 0 of the mac_col row.
module qk_tile_sequencer #(
   parameter int COL         = 8,
   parameter int LOAD_LEN    = COL + 2,
   parameter int N_Q         = 8,
   parameter int DRAIN_LEN   = 6 + COL,
   parameter int AW          = 8,
   parameter int BANK_STRIDE = 128,
   parameter int Q_OFF       = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [7:0]    cfg_tiles,
   input  logic [1:0]    bank_valid,
   input  logic          ofifo_afull,
   output logic          mem_rd_en,
   output logic [AW-1:0] mem_rd_addr,
   output logic [1:0]    o_inst,
   output logic [1:0]    bank_release,
   output logic          busy,
   output logic          done,
   output logic [7:0]    tile_cnt
);
   localparam int PW = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_BANK = 3'd1,
      ST_LOAD      = 3'd2,
      ST_EXEC      = 3'd3,
      ST_DRAIN     = 3'd4
   } state_t;

   state_t        state_r;
   logic [PW-1:0] phase_r;
   logic [AW-1:0] addr_r;
   logic [8:0]    tiles_left_r;
   logic          bank_sel_r;
   logic          load_rd_s;
   logic          exec_rd_s;
   logic [AW-1:0] bank_base_s;

   // Read strobes for this cycle; only execute reads yield to output-FIFO backpressure.
   always_comb begin
      load_rd_s = 1'b0;
      exec_rd_s = 1'b0;
      if (state_r == ST_LOAD) begin
         load_rd_s = 1'b1;
      end else if (state_r == ST_EXEC) begin
         exec_rd_s = ~ofifo_afull;
      end else begin
         load_rd_s = 1'b0;
         exec_rd_s = 1'b0;
      end
   end

   // Base word address of the bank currently owned by the sequencer.
   always_comb begin
      if (bank_sel_r) begin
         bank_base_s = AW'(BANK_STRIDE);
      end else begin
         bank_base_s = {AW{1'b0}};
      end
   end

   assign mem_rd_en   = load_rd_s | exec_rd_s;
   assign mem_rd_addr = addr_r;

   // Tile FSM with registered inst stream, bank hand-back and run bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         phase_r      <= {PW{1'b0}};
         addr_r       <= {AW{1'b0}};
         tiles_left_r <= 9'd0;
         bank_sel_r   <= 1'b0;
         o_inst       <= 2'b00;
         bank_release <= 2'b00;
         busy         <= 1'b0;
         done         <= 1'b0;
         tile_cnt     <= 8'd0;
      end else begin
         // SRAM returns data one cycle after the read, so inst trails the strobe by one.
         o_inst       <= {exec_rd_s, load_rd_s};
         bank_release <= 2'b00;
         done         <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start && !done) begin
                  tiles_left_r <= (cfg_tiles == 8'd0) ? 9'd256 : {1'b0, cfg_tiles};
                  busy         <= 1'b1;
                  tile_cnt     <= 8'd0;
                  state_r      <= ST_WAIT_BANK;
               end
            end
            ST_WAIT_BANK: begin
               if (bank_valid[bank_sel_r]) begin
                  phase_r <= {PW{1'b0}};
                  addr_r  <= bank_base_s;
                  state_r <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (phase_r == PW'(LOAD_LEN - 1)) begin
                  phase_r <= {PW{1'b0}};
                  addr_r  <= bank_base_s + AW'(Q_OFF);
                  state_r <= ST_EXEC;
               end else begin
                  phase_r <= phase_r + PW'(1);
                  addr_r  <= addr_r + AW'(1);
               end
            end
            ST_EXEC: begin
               if (!ofifo_afull) begin
                  addr_r <= addr_r + AW'(1);
                  if (phase_r == PW'(N_Q - 1)) begin
                     phase_r <= {PW{1'b0}};
                     state_r <= ST_DRAIN;
                  end else begin
                     phase_r <= phase_r + PW'(1);
                  end
               end
            end
            ST_DRAIN: begin
               if (phase_r == PW'(DRAIN_LEN - 1)) begin
                  phase_r      <= {PW{1'b0}};
                  bank_release <= bank_sel_r ? 2'b10 : 2'b01;
                  bank_sel_r   <= ~bank_sel_r;
                  tile_cnt     <= tile_cnt + 8'd1;
                  tiles_left_r <= tiles_left_r - 9'd1;
                  if (tiles_left_r == 9'd1) begin
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     state_r <= ST_IDLE;
                  end else begin
                     state_r <= ST_WAIT_BANK;
                  end
               end else begin
                  phase_r <= phase_r + PW'(1);
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_qk_tile_sequencer.sv
// Scoreboard bench for qk_tile_sequencer: expected reads and tile releases are queued
// when a run is launched; a negedge monitor pops and compares as the DUT produces them.
module tb_qk_tile_sequencer;
   logic       clk = 1'b0;
   logic       reset, start, ofifo_afull;
   logic [7:0] cfg_tiles;
   logic [1:0] bank_valid;
   logic       mem_rd_en;
   logic [7:0] mem_rd_addr;
   logic [1:0] o_inst, bank_release;
   logic       busy, done;
   logic [7:0] tile_cnt;

   always #5 clk = ~clk;

   qk_tile_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .cfg_tiles(cfg_tiles),
      .bank_valid(bank_valid), .ofifo_afull(ofifo_afull), .mem_rd_en(mem_rd_en),
      .mem_rd_addr(mem_rd_addr), .o_inst(o_inst), .bank_release(bank_release),
      .busy(busy), .done(done), .tile_cnt(tile_cnt)
   );

   typedef struct {logic [7:0] addr; logic [1:0] inst;} rd_t;
   typedef struct {logic [1:0] mask; logic [7:0] cnt; bit last; bit bank;} rel_t;

   rd_t  rd_q[$];
   rel_t rel_q[$];
   int   checks = 0, errors = 0;
   int   model_bank = 0;

   // monitor-side expectation state
   int         cyc = 0, mph = 0, loads = 0, execs = 0, beats = 0, rel_due = -1;
   bit         wbank = 1'b0, saw_prev = 1'b0, prev_rst = 1'b0, mbusy = 1'b0;
   logic [1:0] exp_inst_next = 2'b00;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      rd_t        r;
      rel_t       e;
      logic [1:0] exp_rel;
      logic       exp_done;
      cyc++;
      if (reset) begin
         prev_rst = 1'b1;
         rd_q.delete();
         rel_q.delete();
         mph = 0; mbusy = 1'b0; rel_due = -1; exp_inst_next = 2'b00; beats = 0;
      end else begin
         if (prev_rst) begin
            check("rst_rd_en", int'(mem_rd_en), 0);
            check("rst_o_inst", int'(o_inst), 0);
            check("rst_release", int'(bank_release), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_done", int'(done), 0);
            check("rst_tile_cnt", int'(tile_cnt), 0);
            prev_rst = 1'b0;
         end
         exp_rel  = 2'b00;
         exp_done = 1'b0;
         if (cyc == rel_due) begin
            rel_due = -1;
            check("rel_q_nonempty", int'(rel_q.size() > 0), 1);
            if (rel_q.size() > 0) begin
               e = rel_q.pop_front();
               exp_rel = e.mask;
               check("tile_cnt", int'(tile_cnt), int'(e.cnt));
               check("exec_beats", beats, 8);
               if (e.last) begin
                  exp_done = 1'b1;
                  mbusy = 1'b0;
                  mph = 0;
               end else begin
                  mph = 1;
                  saw_prev = 1'b0;
                  if (rel_q.size() > 0) wbank = rel_q[0].bank;
               end
            end
            beats = 0;
         end
         check("bank_release", int'(bank_release), int'(exp_rel));
         check("done", int'(done), int'(exp_done));
         check("busy", int'(busy), int'(mbusy));
         check("o_inst", int'(o_inst), int'(exp_inst_next));
         if (o_inst == 2'b10) beats++;
         exp_inst_next = 2'b00;
         if (mem_rd_en) begin
            check("rd_q_nonempty", int'(rd_q.size() > 0), 1);
            if (rd_q.size() > 0) begin
               r = rd_q.pop_front();
               check("rd_addr", int'(mem_rd_addr), int'(r.addr));
               exp_inst_next = r.inst;
            end
         end
         case (mph)
            0: check("idle_rd", int'(mem_rd_en), 0);
            1: begin
               check("load_start", int'(mem_rd_en), int'(saw_prev));
               if (mem_rd_en) begin
                  mph = 2;
                  loads = 1;
               end else begin
                  saw_prev = bank_valid[wbank];
               end
            end
            2: begin
               check("load_contig", int'(mem_rd_en), 1);
               loads++;
               if (loads == 10) begin
                  mph = 3;
                  execs = 0;
               end
            end
            3: begin
               check("exec_issue", int'(mem_rd_en), int'(!ofifo_afull));
               if (mem_rd_en) begin
                  execs++;
                  if (execs == 8) begin
                     mph = 4;
                     rel_due = cyc + 15;
                  end
               end
            end
            default: check("drain_rd", int'(mem_rd_en), 0);
         endcase
         if (start && !mbusy && !exp_done) begin
            mbusy = 1'b1;
            mph = 1;
            saw_prev = 1'b0;
            if (rel_q.size() > 0) wbank = rel_q[0].bank;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Queue the whole run's reads and releases from the address map, then pulse start.
   task automatic do_start(input int cfg);
      int   n, b, base;
      rd_t  r;
      rel_t e;
      n = (cfg == 0) ? 256 : cfg;
      for (int t = 0; t < n; t++) begin
         b = model_bank ^ (t % 2);
         base = b * 128;
         for (int k = 0; k < 10; k++) begin
            r.addr = 8'(base + k);
            r.inst = 2'b01;
            rd_q.push_back(r);
         end
         for (int q = 0; q < 8; q++) begin
            r.addr = 8'(base + 16 + q);
            r.inst = 2'b10;
            rd_q.push_back(r);
         end
         e.mask = 2'(1 << b);
         e.cnt  = 8'((t + 1) % 256);
         e.last = (t == n - 1);
         e.bank = b[0];
         rel_q.push_back(e);
      end
      model_bank = model_bank ^ (n % 2);
      cfg_tiles = 8'(cfg);
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input int afull_pct, input bit bv_rand);
      int i = 0;
      while ((mbusy || rel_q.size() > 0) && i < budget) begin
         if (afull_pct >= 0) ofifo_afull = ($urandom_range(0, 99) < afull_pct);
         if (bv_rand) bank_valid = 2'($urandom_range(0, 3));
         step();
         i++;
      end
      check("run_timeout", int'(i < budget), 1);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; cfg_tiles = 8'd0; bank_valid = 2'b00; ofifo_afull = 1'b0;
      repeat (3) step();
      reset = 1'b0;
      model_bank = 0;
      step();

      // bank starvation: bank 1 arrives late, load must follow it by one cycle
      bank_valid = 2'b01;
      do_start(2);
      repeat (54) step();
      bank_valid = 2'b11;
      wait_idle(200, -1, 1'b0);

      // backpressure in EXEC cycles 3..5, afull also held during LOAD and DRAIN
      bank_valid = 2'b01;
      do_start(1);
      for (int i = 0; i < 40; i++) begin
         ofifo_afull = (i >= 1 && i <= 10) || (i >= 14 && i <= 16) || (i >= 22 && i <= 35);
         step();
      end
      ofifo_afull = 1'b0;
      wait_idle(100, -1, 1'b0);

      // reset in the middle of EXEC on bank 1
      bank_valid = 2'b11;
      do_start(1);
      repeat (14) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      model_bank = 0;
      repeat (3) step();

      // double buffering with a start while busy
      bank_valid = 2'b11;
      do_start(3);
      repeat (30) step();
      cfg_tiles = 8'd7;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_idle(300, 0, 1'b0);

      // start coincident with done is ignored
      bank_valid = 2'b10;
      do_start(1);
      repeat (33) step();
      cfg_tiles = 8'd5;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (5) step();
      check("busy_after_done_start", int'(busy), 0);
      wait_idle(50, -1, 1'b0);

      // randomized runs with random backpressure and bank availability
      for (int r = 0; r < 6; r++) begin
         do_start($urandom_range(1, 4));
         wait_idle(1000, 30, 1'b1);
      end

      // cfg_tiles = 0 runs 256 tiles and tile_cnt wraps to 0
      bank_valid = 2'b11;
      do_start(0);
      wait_idle(20000, 15, 1'b0);

      ofifo_afull = 1'b0;
      repeat (5) step();
      check("rd_q_drained", rd_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
